pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised chain of pipeline registers, STAGES deep and WIDTH bits wide, with a valid bit per stage, per-stage stall and flush, and backward stall propagation with bubble insertion. It replaces the hand-enumerated inter-stage latches between fetch/decode/execute/memory/writeback with one generic block per datapath bundle. The core instantiates one chain per bundle (instruction word, control, operands).

## Interface
Parameters:
- WIDTH, 32, payload bits per stage
- STAGES, 4, number of register stages (≥1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  stage-0 input payload is valid
- in_data  in  WIDTH  stage-0 input payload
- in_ready  out  1  stage 0 accepts input this cycle; = !hold[0]
- stall  in  STAGES  stall[k] holds stage k and every stage upstream of it
- flush  in  STAGES  flush[k] invalidates stage k this edge
- out_valid  out  STAGES  V[k], valid bit of stage k
- out_data  out  STAGES*WIDTH  R[k] at bits [k*WIDTH +: WIDTH]
- stall_cnt  out  32  only with PIPE_PERF_EN
- flush_cnt  out  32  only with PIPE_PERF_EN

## Operation
- State per stage k: R[k] (WIDTH), V[k] (1). Source of stage 0 is in_data/in_valid; source of stage k>0 is R[k-1]/V[k-1].
- hold[k] = OR of stall[j] for all j ≥ k (combinational, backward propagation).
- Per-edge update of stage k, in priority order:
  - flush[k]=1: V[k]←0, R[k]←0. Flush wins over stall and hold.
  - hold[k]=1: R[k], V[k] unchanged.
  - k>0 and hold[k-1]=1 (only when stall[k-1] asserted, since hold[k]=0): bubble; V[k]←0, R[k]←0.
  - otherwise: R[k]←source data, V[k]←source valid.
- Zeroed payload on flush/bubble is required: downstream decode treats all-zero as NOP.
- in_valid with in_ready=0 is not captured; the producer holds its payload.
- Flushes are independent per stage; callers wanting "flush everything upstream of k" drive the bit-mask themselves.
- Invalid stages still shift (V=0 entries move like data); there is no bubble collapsing.

## Timing
- Reset (async, nRST=0): all R[k]=0, all V[k]=0, counters 0, immediately regardless of CLK.
- Latency: a payload accepted at edge n appears on stage k after edge n+k (stage 0 after edge n), reaching stage STAGES-1 after STAGES edges with no stalls.
- Throughput: one payload per cycle when no stall/flush.
- in_ready and hold are combinational from stall; no registered path. Outputs are purely registered.
- Simultaneous stall[k] and flush[k]: stage k clears, upstream stages still hold.
- Simultaneous flush[k] and bubble condition: identical result (cleared).
- Reset released mid-stream: first edge after release behaves as normal update from an all-empty pipeline.

## Configuration
- PIPE_PERF_EN defined: stall_cnt and flush_cnt ports exist. stall_cnt increments on every edge where |stall=1; flush_cnt increments on every edge where |flush=1. Both saturate at 32'hFFFF_FFFF, reset to 0, not affected by flush.
- PIPE_PERF_EN undefined: both ports and counters absent; remaining behaviour identical.

## Test plan
- Reset then stream in_data=1,2,3,4,5 with in_valid=1, STAGES=4 -> value 1 at out_data stage 3 with out_valid[3]=1 after the 4th edge; 2,3,4,5 follow on consecutive edges.
- Fill pipe with A,B,C,D (stage 3..0), stall[2]=1 for two cycles -> stages 0–2 hold D,C,B; in_ready=0; stage 3 takes a bubble (V=0, data 0) and keeps it for the second cycle; after release B reaches stage 3.
- Pipe full, flush=4'b0011 for one edge -> V[0]=V[1]=0, R[0]=R[1]=0; stages 2,3 advance normally.
- stall[1]=1 and flush[1]=1 same cycle with stage 1 holding 32'hDEADBEEF -> stage 1 becomes V=0/0, stage 0 held, stage 2 gets bubble.
- nRST pulsed low between edges while pipe full -> all out_valid=0 and out_data=0 before the next rising edge.
- With PIPE_PERF_EN: 3 stall cycles and 2 flush cycles -> stall_cnt=3, flush_cnt=2; counter preloaded by force to 32'hFFFF_FFFF stays there on a further stall.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Handshake/bus bundle for pipe_stage_chain: producer payload, per-stage
// stall/flush controls and the registered stage outputs.
interface pipe_stage_chain_if #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
);
   logic                      in_valid;
   logic [WIDTH-1:0]          in_data;
   logic                      in_ready;
   logic [STAGES-1:0]         stall;
   logic [STAGES-1:0]         flush;
   logic [STAGES-1:0]         out_valid;
   logic [STAGES*WIDTH-1:0]   out_data;

   modport master (
      output in_valid, in_data, stall, flush,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, stall, flush,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// Generic STAGES-deep pipeline register chain with per-stage stall/flush,
// backward stall propagation and bubble insertion. Optional PIPE_PERF_EN adds counters.
module pipe_stage_chain #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic               CLK,
   input  logic               nRST,
   pipe_stage_chain_if.slave  bus
`ifdef PIPE_PERF_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
`endif
);

   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] up_hold;
   logic [STAGES-1:0] src_valid;
   logic [WIDTH-1:0]  src_data [STAGES];
   logic [WIDTH-1:0]  r        [STAGES];
   logic [STAGES-1:0] v;

   // hold[k] is the OR of stall[k..STAGES-1]; accumulate from the tail.
   always_comb begin : hold_chain
      logic acc;
      // NOTE: combinational blocks use blocking '=' and assign every output
      // before any branch, so no latch can be inferred.
      acc  = 1'b0;
      hold = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc     = acc | bus.stall[k];
         hold[k] = acc;
      end
   end

   assign bus.in_ready = ~hold[0];

   always_comb begin
      src_data[0]  = bus.in_data;
      src_valid[0] = bus.in_valid;
      up_hold[0]   = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         src_data[k]  = r[k-1];
         src_valid[k] = v[k-1];
         up_hold[k]   = hold[k-1];
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         // NOTE: the stage registers are real flops, not a RAM, and downstream
         // decode relies on all-zero payloads, so every word is reset.
         for (int k = 0; k < STAGES; k++) r[k] <= '0;
         v <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so every stage
         // samples its upstream neighbour's pre-edge value.
         for (int k = 0; k < STAGES; k++) begin
            if (bus.flush[k]) begin
               r[k] <= '0;
               v[k] <= 1'b0;
            end else if (hold[k]) begin
               r[k] <= r[k];
               v[k] <= v[k];
            end else if (up_hold[k]) begin
               // Upstream is frozen but this stage drains: insert a zeroed bubble.
               r[k] <= '0;
               v[k] <= 1'b0;
            end else begin
               r[k] <= src_data[k];
               v[k] <= src_valid[k];
            end
         end
      end
   end

   assign bus.out_valid = v;

   always_comb begin
      bus.out_data = '0;
      for (int k = 0; k < STAGES; k++) bus.out_data[k*WIDTH +: WIDTH] = r[k];
   end

`ifdef PIPE_PERF_EN
   // Saturating event counters; only reset clears them, flush does not.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (|bus.stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
         if (|bus.flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed literal cases plus a
// randomized run compared every cycle against a behavioural model.
module tb_pipe_stage_chain;
   localparam int W = 32;
   localparam int S = 4;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   pipe_stage_chain_if #(.WIDTH(W), .STAGES(S)) bus ();

`ifdef PIPE_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   pipe_stage_chain #(.WIDTH(W), .STAGES(S)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .bus       (bus)
`ifdef PIPE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   bit cmp_en      = 1'b0;

   // Behavioural model state
   logic [W-1:0] m_r [S];
   logic [S-1:0] m_v;
   logic [31:0]  m_sc;
   logic [31:0]  m_fc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] stage_data(input int k);
      return bus.out_data[k*W +: W];
   endfunction

   // Model: a stage is frozen if any stall at or behind it is set; it takes a
   // bubble when the stage just upstream is the one stalling.
   always @(posedge CLK or negedge nRST) begin : model
      logic [W-1:0] nr [S];
      logic [S-1:0] nv;
      if (!nRST) begin
         for (int k = 0; k < S; k++) m_r[k] <= '0;
         m_v  <= '0;
         m_sc <= '0;
         m_fc <= '0;
      end else begin
         for (int k = 0; k < S; k++) begin
            if (bus.flush[k]) begin
               nr[k] = '0;  nv[k] = 1'b0;
            end else if ((bus.stall >> k) != '0) begin
               nr[k] = m_r[k];  nv[k] = m_v[k];
            end else if (k > 0 && bus.stall[k-1]) begin
               nr[k] = '0;  nv[k] = 1'b0;
            end else if (k == 0) begin
               nr[k] = bus.in_data;  nv[k] = bus.in_valid;
            end else begin
               nr[k] = m_r[k-1];  nv[k] = m_v[k-1];
            end
         end
         m_r <= nr;
         m_v <= nv;
         if (bus.stall != '0 && m_sc != 32'hFFFF_FFFF) m_sc <= m_sc + 1;
         if (bus.flush != '0 && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge CLK) begin
      if (cmp_en) begin
         for (int k = 0; k < S; k++) begin
            check($sformatf("model_valid%0d", k), 64'(bus.out_valid[k]), 64'(m_v[k]));
            check($sformatf("model_data%0d", k), 64'(stage_data(k)), 64'(m_r[k]));
         end
         check("model_in_ready", 64'(bus.in_ready), 64'(bus.stall == '0));
`ifdef PIPE_PERF_EN
         check("model_stall_cnt", 64'(stall_cnt), 64'(m_sc));
         check("model_flush_cnt", 64'(flush_cnt), 64'(m_fc));
`endif
      end
   end

   task automatic drive(input logic vld, input logic [W-1:0] d,
                        input logic [S-1:0] st, input logic [S-1:0] fl);
      bus.in_valid = vld;
      bus.in_data  = d;
      bus.stall    = st;
      bus.flush    = fl;
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic fill_abcd();
      drive(1'b1, 32'hA, '0, '0); tick();
      drive(1'b1, 32'hB, '0, '0); tick();
      drive(1'b1, 32'hC, '0, '0); tick();
      drive(1'b1, 32'hD, '0, '0); tick();
   endtask

   initial begin
      logic [S-1:0] st;
      logic [S-1:0] fl;
      drive(1'b0, '0, '0, '0);
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #2 nRST = 1'b1;
      cmp_en = 1'b1;

      check("reset_valid", 64'(bus.out_valid), 64'(0));
      check("reset_data", 64'(bus.out_data), 64'(0));
      check("reset_in_ready", 64'(bus.in_ready), 64'(1));

      // Streaming latency and throughput
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i), '0, '0); tick();
      end
      check("stream_v3_first", 64'(bus.out_valid[3]), 64'(1));
      check("stream_d3_first", 64'(stage_data(3)), 64'(1));
      drive(1'b1, 32'd5, '0, '0); tick();
      check("stream_d3_2", 64'(stage_data(3)), 64'(2));
      drive(1'b0, '0, '0, '0);
      for (int i = 3; i <= 5; i++) begin
         tick();
         check($sformatf("stream_d3_%0d", i), 64'(stage_data(3)), 64'(i));
      end

      // Stall on stage 2: upstream holds, stage 3 takes a bubble
      fill_abcd();
      drive(1'b1, 32'hE, 4'b0100, '0);
      #1 check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      for (int c = 0; c < 2; c++) begin
         tick();
         check("stall_d0", 64'(stage_data(0)), 64'(32'hD));
         check("stall_d1", 64'(stage_data(1)), 64'(32'hC));
         check("stall_d2", 64'(stage_data(2)), 64'(32'hB));
         check("stall_v3", 64'(bus.out_valid[3]), 64'(0));
         check("stall_d3", 64'(stage_data(3)), 64'(0));
      end
      drive(1'b0, '0, '0, '0); tick();
      check("release_d3", 64'(stage_data(3)), 64'(32'hB));
      check("release_v3", 64'(bus.out_valid[3]), 64'(1));

      // Flush stages 0 and 1
      fill_abcd();
      drive(1'b1, 32'hE, '0, 4'b0011); tick();
      check("flush_v", 64'(bus.out_valid), 64'(4'b1100));
      check("flush_d0", 64'(stage_data(0)), 64'(0));
      check("flush_d1", 64'(stage_data(1)), 64'(0));
      check("flush_d2", 64'(stage_data(2)), 64'(32'hC));
      check("flush_d3", 64'(stage_data(3)), 64'(32'hB));

      // Stall and flush on the same stage
      drive(1'b1, 32'hDEADBEEF, '0, '0); tick();
      drive(1'b1, 32'h1111, '0, '0); tick();
      check("sf_pre_d1", 64'(stage_data(1)), 64'(32'hDEADBEEF));
      drive(1'b1, 32'h2222, 4'b0010, 4'b0010); tick();
      check("sf_v1", 64'(bus.out_valid[1]), 64'(0));
      check("sf_d1", 64'(stage_data(1)), 64'(0));
      check("sf_d0", 64'(stage_data(0)), 64'(32'h1111));
      check("sf_v0", 64'(bus.out_valid[0]), 64'(1));
      check("sf_v2", 64'(bus.out_valid[2]), 64'(0));
      check("sf_d2", 64'(stage_data(2)), 64'(0));

      // Asynchronous reset between edges
      fill_abcd();
      #1 nRST = 1'b0;
      #1 check("areset_valid", 64'(bus.out_valid), 64'(0));
      check("areset_data", 64'(bus.out_data), 64'(0));
      nRST = 1'b1;
      drive(1'b0, '0, '0, '0); tick();

`ifdef PIPE_PERF_EN
      #1 nRST = 1'b0;
      #1 nRST = 1'b1;
      for (int i = 0; i < 3; i++) begin drive(1'b1, 32'(i), 4'b0001, '0); tick(); end
      for (int i = 0; i < 2; i++) begin drive(1'b1, 32'(i), '0, 4'b0100); tick(); end
      drive(1'b0, '0, '0, '0); tick();
      check("perf_stall_cnt", 64'(stall_cnt), 64'(3));
      check("perf_flush_cnt", 64'(flush_cnt), 64'(2));
`endif

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         for (int k = 0; k < S; k++) begin
            st[k] = ($urandom_range(0, 7) == 0);
            fl[k] = ($urandom_range(0, 15) == 0);
         end
         drive($urandom_range(0, 9) < 7, $urandom, st, fl);
         if ($urandom_range(0, 199) == 0) begin
            #1 nRST = 1'b0;
            #1 nRST = 1'b1;
         end
         tick();
      end
      drive(1'b0, '0, '0, '0);
      @(negedge CLK);
      #1 cmp_en = 1'b0;

`ifdef PIPE_PERF_EN
      force dut.stall_cnt = 32'hFFFF_FFFF;
      #1 release dut.stall_cnt;
      drive(1'b0, '0, 4'b0001, '0); tick();
      check("perf_stall_sat", 64'(stall_cnt), 64'(32'hFFFF_FFFF));
      drive(1'b0, '0, '0, '0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
